// File: rtl/stdp_array_if.sv
// Control, spike and readback/write-notification bundle of the STDP array.
interface stdp_array_if #(
  parameter int N_PRE   = 8,
  parameter int N_POST  = 4,
  parameter int W_WIDTH = 16,
  parameter int AW      = 5
);
  logic                      EN;
  logic                      STEP;
  logic [N_PRE-1:0]          PRE_SPIKES;
  logic [N_POST-1:0]         POST_SPIKES;
  logic [AW-1:0]             RD_ADDR;
  logic signed [W_WIDTH-1:0] RD_DATA;
  logic                      BUSY;
  logic                      DONE;
  logic                      WE;
  logic [AW-1:0]             ADDR;
  logic signed [W_WIDTH-1:0] WEIGHT;

  modport master (
    output EN, STEP, PRE_SPIKES, POST_SPIKES, RD_ADDR,
    input  RD_DATA, BUSY, DONE, WE, ADDR, WEIGHT
  );

  modport slave (
    input  EN, STEP, PRE_SPIKES, POST_SPIKES, RD_ADDR,
    output RD_DATA, BUSY, DONE, WE, ADDR, WEIGHT
  );
endinterface

// File: rtl/stdp_array.sv
// Pair-based STDP learning array. Each STEP scans every synapse once
// (pre index fastest), applying clamped LTP/LTD against per-neuron
// decaying spike timers, then ages the timers in a single FIN cycle.
module stdp_array #(
  parameter int N_PRE    = 8,
  parameter int N_POST   = 4,
  parameter int W_WIDTH  = 16,
  parameter int W_MIN    = -1024,
  parameter int W_MAX    = 1024,
  parameter int W_INIT   = 0,
  parameter int LTP_STEP = 16,
  parameter int LTD_STEP = 16,
  parameter int PRE_WIN  = 15,
  parameter int POST_WIN = 5,
  localparam int N_SYN   = N_PRE * N_POST,
  localparam int AW      = $clog2(N_SYN)
) (
  input  logic        CLK,
  input  logic        RST,
  stdp_array_if.slave bus
);

  localparam int PIW   = (N_PRE > 1) ? $clog2(N_PRE) : 1;
  localparam int QIW   = (N_POST > 1) ? $clog2(N_POST) : 1;
  localparam int T_MAX = (PRE_WIN > POST_WIN) ? PRE_WIN : POST_WIN;
  localparam int TW    = $clog2(T_MAX + 1);

  localparam logic signed [W_WIDTH:0]   W_MAX_X  = (W_WIDTH+1)'(W_MAX);
  localparam logic signed [W_WIDTH:0]   W_MIN_X  = (W_WIDTH+1)'(W_MIN);
  localparam logic signed [W_WIDTH:0]   LTP_X    = (W_WIDTH+1)'(LTP_STEP);
  localparam logic signed [W_WIDTH:0]   LTD_X    = (W_WIDTH+1)'(LTD_STEP);
  localparam logic signed [W_WIDTH-1:0] W_INIT_W = W_WIDTH'(W_INIT);
  localparam logic [TW-1:0]             PRE_WIN_T  = TW'(PRE_WIN);
  localparam logic [TW-1:0]             POST_WIN_T = TW'(POST_WIN);
  localparam logic [AW-1:0]             LAST_IDX   = AW'(N_SYN - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, FIN = 2'd2} state_t;

  state_t                    state_r, state_s;
  logic [AW-1:0]             idx_r;
  logic [N_PRE-1:0]          pre_lat_r;
  logic [N_POST-1:0]         post_lat_r;
  logic [TW-1:0]             pre_tmr_r  [N_PRE];
  logic [TW-1:0]             post_tmr_r [N_POST];
  logic signed [W_WIDTH-1:0] mem_r      [N_SYN];

  logic [PIW-1:0]            pre_i_s;
  logic [QIW-1:0]            post_j_s;
  logic signed [W_WIDTH-1:0] w_old_s, w_new_s;
  logic signed [W_WIDTH:0]   w_ext_s, sum_s;
  logic                      ltp_s, ltd_s, wr_s, last_s, accept_s;

  logic                      busy_r, done_r, we_r;
  logic [AW-1:0]             addr_r;
  logic signed [W_WIDTH-1:0] weight_r, rd_data_r;

  // Saturate a widened weight into [W_MIN, W_MAX]; the extra bit keeps the sum from wrapping.
  function automatic logic signed [W_WIDTH:0] clamp_w(input logic signed [W_WIDTH:0] v);
    if (v > W_MAX_X) begin
      return W_MAX_X;
    end else if (v < W_MIN_X) begin
      return W_MIN_X;
    end else begin
      return v;
    end
  endfunction

  // Synapse datapath: decode the scan index, evaluate the learning rule, detect a real change.
  always_comb begin
    pre_i_s  = PIW'(idx_r % AW'(N_PRE));
    post_j_s = QIW'(idx_r / AW'(N_PRE));
    w_old_s  = mem_r[idx_r];
    w_ext_s  = {w_old_s[W_WIDTH-1], w_old_s};
    ltp_s    = post_lat_r[post_j_s] & ~pre_lat_r[pre_i_s] & (pre_tmr_r[pre_i_s] != '0);
    ltd_s    = pre_lat_r[pre_i_s] & ~post_lat_r[post_j_s] & (post_tmr_r[post_j_s] != '0);
    if (ltp_s) begin
      sum_s = clamp_w(w_ext_s + LTP_X);
    end else if (ltd_s) begin
      sum_s = clamp_w(w_ext_s - LTD_X);
    end else begin
      sum_s = w_ext_s;
    end
    w_new_s  = sum_s[W_WIDTH-1:0];
    wr_s     = (state_r == SCAN) && (w_new_s != w_old_s);
    last_s   = (idx_r == LAST_IDX);
    accept_s = (state_r == IDLE) && bus.STEP;
  end

  // Next-state logic: IDLE waits for STEP, SCAN walks all synapses, FIN ages timers.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.STEP) state_s = SCAN;
        else          state_s = IDLE;
      end
      SCAN: begin
        if (last_s) state_s = FIN;
        else        state_s = SCAN;
      end
      FIN:     state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State register; a low EN freezes the scan in place.
  always_ff @(posedge CLK) begin
    if (RST)         state_r <= IDLE;
    else if (bus.EN) state_r <= state_s;
  end

  // Spike latches and scan index.
  always_ff @(posedge CLK) begin
    if (RST) begin
      idx_r      <= '0;
      pre_lat_r  <= '0;
      post_lat_r <= '0;
    end else if (bus.EN) begin
      if (accept_s) begin
        idx_r      <= '0;
        pre_lat_r  <= bus.PRE_SPIKES;
        post_lat_r <= bus.POST_SPIKES;
      end else if (state_r == SCAN) begin
        idx_r <= idx_r + AW'(1);
      end
    end
  end

  // Weight RAM: reset to W_INIT, written only when a synapse actually changes.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int n = 0; n < N_SYN; n++) mem_r[n] <= W_INIT_W;
    end else if (bus.EN && wr_s) begin
      mem_r[idx_r] <= w_new_s;
    end
  end

  // Spike timers: reload on a latched spike, otherwise count down to zero, once per step.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < N_PRE; i++)  pre_tmr_r[i]  <= '0;
      for (int j = 0; j < N_POST; j++) post_tmr_r[j] <= '0;
    end else if (bus.EN && (state_r == FIN)) begin
      for (int i = 0; i < N_PRE; i++) begin
        if (pre_lat_r[i])             pre_tmr_r[i] <= PRE_WIN_T;
        else if (pre_tmr_r[i] != '0)  pre_tmr_r[i] <= pre_tmr_r[i] - TW'(1);
      end
      for (int j = 0; j < N_POST; j++) begin
        if (post_lat_r[j])            post_tmr_r[j] <= POST_WIN_T;
        else if (post_tmr_r[j] != '0) post_tmr_r[j] <= post_tmr_r[j] - TW'(1);
      end
    end
  end

  // Status and write-notification registers; EN low silences WE/DONE but keeps BUSY.
  always_ff @(posedge CLK) begin
    if (RST) begin
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      we_r     <= 1'b0;
      addr_r   <= '0;
      weight_r <= '0;
    end else if (!bus.EN) begin
      we_r   <= 1'b0;
      done_r <= 1'b0;
    end else begin
      we_r   <= wr_s;
      done_r <= (state_r == SCAN) && last_s;
      busy_r <= (state_s != IDLE);
      if (wr_s) begin
        addr_r   <= idx_r;
        weight_r <= w_new_s;
      end
    end
  end

  // Readback port: previous-cycle RAM contents, no write forwarding.
  always_ff @(posedge CLK) begin
    if (RST) rd_data_r <= '0;
    else     rd_data_r <= mem_r[bus.RD_ADDR];
  end

  assign bus.RD_DATA = rd_data_r;
  assign bus.BUSY    = busy_r;
  assign bus.DONE    = done_r;
  assign bus.WE      = we_r;
  assign bus.ADDR    = addr_r;
  assign bus.WEIGHT  = weight_r;

endmodule
